// File: rtl/ecc_dec_pkg.sv
// Shared Hamming(72,64) definitions: data-bit position table, check-bit
// encoder, scrub FSM states and the per-word error class.
package ecc_dec_pkg;

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        CE    = 2'd1,
        UE    = 2'd2
    } err_cls_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } scrub_state_e;

    // Data bit i sits at the i-th non-power-of-two position in 3..71.
    function automatic logic [63:0][6:0] gen_data_pos();
        logic [63:0][6:0] t;
        logic [6:0]       idx;
        t   = '0;
        idx = '0;
        for (int p = 3; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                t[idx[5:0]] = 7'(p);
                idx         = idx + 7'd1;
            end
        end
        return t;
    endfunction

    localparam logic [63:0][6:0] DATA_POS = gen_data_pos();

    function automatic logic [6:0] calc_chk(input logic [63:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            for (int k = 0; k < 7; k++) begin
                if (DATA_POS[i][k]) c[k] = c[k] ^ d[i];
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] ecc_encode(input logic [63:0] d);
        logic [6:0] c;
        c = calc_chk(d);
        return {(^d) ^ (^c), c};
    endfunction

endpackage

// File: rtl/ecc_dec_syndrome.sv
// Combinational syndrome, overall parity and error classification of one
// received 72-bit codeword.
module ecc_dec_syndrome
    import ecc_dec_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int EWIDTH = 8
) (
    input  logic [DWIDTH-1:0] data_i,
    input  logic [EWIDTH-1:0] ecc_i,
    output logic [6:0]        syn_o,
    output logic              par_o,
    output err_cls_e          cls_o
);

    always_comb begin
        syn_o = calc_chk(data_i) ^ ecc_i[6:0];
        par_o = ^{data_i, ecc_i};
        cls_o = CLEAN;
        if (par_o) begin
            // s=0 with odd parity is a flip of the overall check bit itself.
            cls_o = (syn_o > 7'd71) ? UE : CE;
        end else if (syn_o != 7'd0) begin
            cls_o = UE;
        end
    end

endmodule

// File: rtl/ecc_dec_scrub.sv
// Two-stage SECDED decoder with error counters and an optional scrub
// write-back request path, built only when ECC_DEC_SCRUB_EN is defined.
module ecc_dec_scrub
    import ecc_dec_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int EWIDTH = 8,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [EWIDTH-1:0] in_ecc,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_ce,
    output logic              out_ue,
    input  logic              out_ready,
    output logic              scrub_req,
    output logic [DWIDTH-1:0] scrub_data,
    output logic [EWIDTH-1:0] scrub_ecc,
    output logic [TAG_W-1:0]  scrub_tag,
    input  logic              scrub_ack,
    input  logic              cfg_correct_en,
    input  logic              cfg_scrub_en,
    input  logic              cfg_cnt_clr,
    output logic [CNT_W-1:0]  ce_cnt,
    output logic [CNT_W-1:0]  ue_cnt,
    output logic [CNT_W-1:0]  scrub_drop_cnt,
    output logic [7:0]        first_syn,
    output logic              first_syn_vld,
    output logic              dbg_scrub_state
);

    // Handshake: a beat moves on either port when valid and ready are both
    // high at a clock edge; both stages advance together whenever the output
    // register is empty or being drained (adv), and in_ready mirrors adv.
    logic              adv, fire, accept;
    logic [6:0]        syn;
    logic              par;
    err_cls_e          cls;

    logic              s1_vld_q;
    logic [DWIDTH-1:0] s1_data_q;
    logic [TAG_W-1:0]  s1_tag_q;
    logic [6:0]        s1_syn_q;
    logic              s1_par_q;
    err_cls_e          s1_cls_q;

    logic              out_valid_q, out_ce_q, out_ue_q;
    logic [DWIDTH-1:0] out_data_q, corr_data, flip_mask;
    logic [TAG_W-1:0]  out_tag_q;
    logic [7:0]        out_syn_q;

    logic [CNT_W-1:0]  ce_cnt_q, ue_cnt_q;
    logic [7:0]        first_syn_q;
    logic              first_syn_vld_q;

    ecc_dec_syndrome #(.DWIDTH(DWIDTH), .EWIDTH(EWIDTH)) u_syndrome (
        .data_i (in_data),
        .ecc_i  (in_ecc),
        .syn_o  (syn),
        .par_o  (par),
        .cls_o  (cls)
    );

    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv & rst_n;
    assign accept   = in_valid & in_ready;
    assign fire     = out_valid_q & out_ready;

    always_comb begin
        flip_mask = '0;
        if (cfg_correct_en && s1_cls_q == CE) begin
            for (int i = 0; i < DWIDTH; i++) flip_mask[i] = (DATA_POS[i] == s1_syn_q);
        end
        corr_data = s1_data_q ^ flip_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_ce_q    <= 1'b0;
            out_ue_q    <= 1'b0;
        end else if (adv) begin
            s1_vld_q    <= accept;
            out_valid_q <= s1_vld_q;
            out_ce_q    <= s1_vld_q && (s1_cls_q == CE);
            out_ue_q    <= s1_vld_q && (s1_cls_q == UE);
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_data_q  <= in_data;
            s1_tag_q   <= in_tag;
            s1_syn_q   <= syn;
            s1_par_q   <= par;
            s1_cls_q   <= cls;
            out_data_q <= corr_data;
            out_tag_q  <= s1_tag_q;
            out_syn_q  <= {s1_par_q, s1_syn_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ce_cnt_q        <= '0;
            ue_cnt_q        <= '0;
            first_syn_q     <= '0;
            first_syn_vld_q <= 1'b0;
        end else if (cfg_cnt_clr) begin
            ce_cnt_q        <= '0;
            ue_cnt_q        <= '0;
            first_syn_vld_q <= 1'b0;
        end else begin
            if (fire && out_ce_q && !(&ce_cnt_q)) ce_cnt_q <= ce_cnt_q + 1'b1;
            if (fire && out_ue_q && !(&ue_cnt_q)) ue_cnt_q <= ue_cnt_q + 1'b1;
            if (fire && (out_ce_q || out_ue_q) && !first_syn_vld_q) begin
                first_syn_q     <= out_syn_q;
                first_syn_vld_q <= 1'b1;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_tag       = out_tag_q;
    assign out_ce        = out_ce_q;
    assign out_ue        = out_ue_q;
    assign ce_cnt        = ce_cnt_q;
    assign ue_cnt        = ue_cnt_q;
    assign first_syn     = first_syn_q;
    assign first_syn_vld = first_syn_vld_q;

`ifdef ECC_DEC_SCRUB_EN
    scrub_state_e      state_q, state_d;
    logic              scrub_elig, scrub_load, scrub_drop;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [DWIDTH-1:0] scrub_data_q;
    logic [EWIDTH-1:0] scrub_ecc_q;
    logic [TAG_W-1:0]  scrub_tag_q;

    assign scrub_elig = fire & out_ce_q & cfg_scrub_en & cfg_correct_en;

    always_comb begin
        state_d    = state_q;
        scrub_load = 1'b0;
        scrub_drop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (scrub_elig) begin
                    scrub_load = 1'b1;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                // An ack frees the slot in the same cycle a new CE may claim it.
                if (scrub_ack) begin
                    if (scrub_elig) scrub_load = 1'b1;
                    else            state_d    = S_IDLE;
                end else if (scrub_elig) begin
                    scrub_drop = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            drop_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (cfg_cnt_clr)                          drop_cnt_q <= '0;
            else if (scrub_drop && !(&drop_cnt_q))    drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (scrub_load) begin
            scrub_data_q <= out_data_q;
            scrub_ecc_q  <= ecc_encode(out_data_q);
            scrub_tag_q  <= out_tag_q;
        end
    end

    assign scrub_req       = (state_q == S_REQ);
    assign scrub_data      = scrub_data_q;
    assign scrub_ecc       = scrub_ecc_q;
    assign scrub_tag       = scrub_tag_q;
    assign scrub_drop_cnt  = drop_cnt_q;
    assign dbg_scrub_state = state_q;
`else
    logic unused_scrub;
    assign unused_scrub    = ^{scrub_ack, cfg_scrub_en};
    assign scrub_req       = 1'b0;
    assign scrub_data      = '0;
    assign scrub_ecc       = '0;
    assign scrub_tag       = '0;
    assign scrub_drop_cnt  = '0;
    assign dbg_scrub_state = S_IDLE;
`endif

endmodule

// File: tb/tb_ecc_dec_scrub.sv
// Directed scoreboard bench for ecc_dec_scrub: a driver pushes hand-computed
// responses, a negedge monitor pops and compares every output beat.
module tb_ecc_dec_scrub;

    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [63:0]       in_data, out_data, scrub_data;
    logic [7:0]        in_ecc, in_tag, out_tag, scrub_ecc, scrub_tag, first_syn;
    logic              out_ce, out_ue, scrub_req, scrub_ack;
    logic              cfg_correct_en, cfg_scrub_en, cfg_cnt_clr, first_syn_vld;
    logic              dbg_scrub_state;
    logic [CNT_W-1:0]  ce_cnt, ue_cnt, scrub_drop_cnt;

    int                err = 0;
    int                chk = 0;
    logic [73:0]       exp_q[$];

    logic              hold_v = 1'b0;
    logic [63:0]       hold_data;
    logic [7:0]        hold_tag;

    // Directed vectors: data, ecc, expected data, expected ce, expected ue.
    logic [63:0] vd [7] = '{64'h0, 64'h0, 64'h0, 64'h1, 64'h11, 64'h10, 64'h8000_0000_0000_0000};
    logic [7:0]  ve [7] = '{8'h01, 8'h80, 8'h7f, 8'h83, 8'h83, 8'h00, 8'h00};
    logic [63:0] vx [7] = '{64'h0, 64'h0, 64'h0, 64'h1, 64'h1, 64'h0, 64'h0};
    logic        vc [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        vu [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    always #5 clk = ~clk;

    ecc_dec_scrub #(.DWIDTH(64), .EWIDTH(8), .TAG_W(8), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ecc          (in_ecc),
        .in_tag          (in_tag),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_tag         (out_tag),
        .out_ce          (out_ce),
        .out_ue          (out_ue),
        .out_ready       (out_ready),
        .scrub_req       (scrub_req),
        .scrub_data      (scrub_data),
        .scrub_ecc       (scrub_ecc),
        .scrub_tag       (scrub_tag),
        .scrub_ack       (scrub_ack),
        .cfg_correct_en  (cfg_correct_en),
        .cfg_scrub_en    (cfg_scrub_en),
        .cfg_cnt_clr     (cfg_cnt_clr),
        .ce_cnt          (ce_cnt),
        .ue_cnt          (ue_cnt),
        .scrub_drop_cnt  (scrub_drop_cnt),
        .first_syn       (first_syn),
        .first_syn_vld   (first_syn_vld),
        .dbg_scrub_state (dbg_scrub_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] e, input logic [7:0] t,
                        input logic [63:0] xd, input logic xce, input logic xue, input bit push);
        int   n;
        logic rdy;
        in_valid = 1'b1;
        in_data  = d;
        in_ecc   = e;
        in_tag   = t;
        n        = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        if (!rdy) begin
            chk++;
            err++;
            $display("FAIL send_timeout: tag 0x%0h not accepted after %0d cycles, required acceptance", t, n);
        end else if (push) begin
            exp_q.push_back({xd, t, xce, xue});
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            step(1);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk++;
            err++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
        step(1);
    endtask

    task automatic pulse_clr();
        cfg_cnt_clr = 1'b1;
        step(1);
        cfg_cnt_clr = 1'b0;
    endtask

    // Monitor: score every accepted output beat and check stall stability.
    always @(negedge clk) begin
        logic [73:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk++;
                err++;
                $display("FAIL out_unexpected: got beat tag 0x%0h, required no output", out_tag);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e[73:10]);
                check("out_tag", 64'(out_tag), 64'(e[9:2]));
                check("out_ce", 64'(out_ce), 64'(e[1]));
                check("out_ue", 64'(out_ue), 64'(e[0]));
            end
        end
        if (rst_n && hold_v) begin
            check("hold_data", out_data, hold_data);
            check("hold_tag", 64'(out_tag), 64'(hold_tag));
        end
        hold_v    = rst_n && out_valid && !out_ready;
        hold_data = out_data;
        hold_tag  = out_tag;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        in_valid       = 1'b0;
        in_data        = '0;
        in_ecc         = '0;
        in_tag         = '0;
        out_ready      = 1'b1;
        scrub_ack      = 1'b0;
        cfg_correct_en = 1'b1;
        cfg_scrub_en   = 1'b0;
        cfg_cnt_clr    = 1'b0;

        // Reset state
        rst_n = 1'b0;
        step(3);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        step(1);
        check("rst_ce_cnt", 64'(ce_cnt), 64'd0);
        check("rst_ue_cnt", 64'(ue_cnt), 64'd0);
        check("rst_drop_cnt", 64'(scrub_drop_cnt), 64'd0);
        check("rst_first_syn", 64'(first_syn), 64'd0);
        check("rst_first_syn_vld", 64'(first_syn_vld), 64'd0);
        check("rst_scrub_req", 64'(scrub_req), 64'd0);
        check("rst_in_ready_rel", 64'(in_ready), 64'd1);

        // Clean word and two-cycle latency
        send(64'h0, 8'h00, 8'h01, 64'h0, 1'b0, 1'b0, 1'b1);
        idle();
        check("lat_cycle1", 64'(out_valid), 64'd0);
        step(1);
        check("lat_cycle2", 64'(out_valid), 64'd1);
        drain();

        // d0 flipped: s=3, p=1
        send(64'h1, 8'h00, 8'h02, 64'h0, 1'b1, 1'b0, 1'b1);
        idle();
        drain();
        check("ce_cnt_1", 64'(ce_cnt), 64'd1);
        check("first_syn_83", 64'(first_syn), 64'h83);
        check("first_syn_vld_1", 64'(first_syn_vld), 64'd1);

        // Double error: s=6, p=0, never scrubbed
        cfg_scrub_en = 1'b1;
        send(64'h3, 8'h00, 8'h03, 64'h3, 1'b0, 1'b1, 1'b1);
        idle();
        drain();
        check("ue_cnt_1", 64'(ue_cnt), 64'd1);
        check("ue_no_scrub", 64'(scrub_req), 64'd0);
        check("first_syn_kept", 64'(first_syn), 64'h83);
        cfg_scrub_en = 1'b0;

        // Check-bit errors, s>71, clean, d4 and d63 corrections back-to-back
        for (int i = 0; i < 7; i++) send(vd[i], ve[i], 8'(8'h10 + i), vx[i], vc[i], vu[i], 1'b1);
        idle();
        drain();

        // Correction disabled: flags kept, data passes through
        cfg_correct_en = 1'b0;
        send(64'h1, 8'h00, 8'h18, 64'h1, 1'b1, 1'b0, 1'b1);
        send(64'h3, 8'h00, 8'h19, 64'h3, 1'b0, 1'b1, 1'b1);
        idle();
        drain();
        cfg_correct_en = 1'b1;
        check("ce_cnt_7", 64'(ce_cnt), 64'd7);
        check("ue_cnt_3", 64'(ue_cnt), 64'd3);

        // Backpressure: three words offered, output stalled
        out_ready = 1'b0;
        send(64'h1, 8'h83, 8'h31, 64'h1, 1'b0, 1'b0, 1'b1);
        send(64'h0, 8'h00, 8'h32, 64'h0, 1'b0, 1'b0, 1'b1);
        fork
            begin
                send(64'h11, 8'h83, 8'h33, 64'h1, 1'b1, 1'b0, 1'b1);
                idle();
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready", 64'(in_ready), 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset flushes an in-flight word
        send(64'h0, 8'h00, 8'h41, 64'h0, 1'b0, 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        step(1);
        check("flush_in_ready", 64'(in_ready), 64'd0);
        step(1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        step(6);
        check("flush_ce_cnt", 64'(ce_cnt), 64'd0);
        check("flush_first_vld", 64'(first_syn_vld), 64'd0);

        // Two CE words back-to-back with no ack
        cfg_scrub_en = 1'b1;
        send(64'h11, 8'h83, 8'h21, 64'h1, 1'b1, 1'b0, 1'b1);
        send(64'h1, 8'h00, 8'h22, 64'h0, 1'b1, 1'b0, 1'b1);
        idle();
        drain();
`ifdef ECC_DEC_SCRUB_EN
        check("scrub_req_on", 64'(scrub_req), 64'd1);
        check("scrub_tag", 64'(scrub_tag), 64'h21);
        check("scrub_data", scrub_data, 64'h1);
        check("scrub_ecc", 64'(scrub_ecc), 64'h83);
        check("scrub_drop_1", 64'(scrub_drop_cnt), 64'd1);
        check("scrub_state_req", 64'(dbg_scrub_state), 64'd1);
        scrub_ack = 1'b1;
        step(1);
        scrub_ack = 1'b0;
        check("scrub_req_off", 64'(scrub_req), 64'd0);
        check("scrub_state_idle", 64'(dbg_scrub_state), 64'd0);
`else
        check("noscrub_req", 64'(scrub_req), 64'd0);
        check("noscrub_drop", 64'(scrub_drop_cnt), 64'd0);
        check("noscrub_data", scrub_data, 64'h0);
        check("noscrub_tag", 64'(scrub_tag), 64'h0);
`endif
        cfg_scrub_en = 1'b0;

        // Saturation at CNT_W=4 and clear precedence
        pulse_clr();
        check("clr_ce_cnt", 64'(ce_cnt), 64'd0);
        for (int i = 0; i < 17; i++) send(64'h1, 8'h00, 8'(8'h50 + i), 64'h0, 1'b1, 1'b0, 1'b1);
        idle();
        drain();
        check("ce_cnt_sat", 64'(ce_cnt), 64'd15);
        pulse_clr();
        send(64'h1, 8'h00, 8'h70, 64'h0, 1'b1, 1'b0, 1'b1);
        idle();
        drain();
        check("ce_cnt_after_clr", 64'(ce_cnt), 64'd1);
        send(64'h1, 8'h00, 8'h71, 64'h0, 1'b1, 1'b0, 1'b1);
        idle();
        step(1);
        cfg_cnt_clr = 1'b1;
        step(1);
        cfg_cnt_clr = 1'b0;
        check("clr_beat_ce_cnt", 64'(ce_cnt), 64'd0);
        check("clr_beat_first_vld", 64'(first_syn_vld), 64'd0);
        drain();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule

// File: doc/ecc_dec_scrub.md
ECC_DEC_SCRUB -- requirements
Module: ecc_dec_scrub

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, data width; only 64 is supported.
REQ-002 SHALL have parameter EWIDTH, default 8, check width; only 8 is supported.
REQ-003 SHALL have parameter TAG_W, default 8, width of the pass-through address tag.
REQ-004 SHALL have parameter CNT_W, default 16, width of the error counters.
REQ-005 SHALL have ports clk in 1 (the single clock) and rst_n in 1; reset is synchronous and active-low.
REQ-006 SHALL have input ports in_valid (1), in_data (DWIDTH), in_ecc (EWIDTH) and in_tag (TAG_W), and output port in_ready (1).
REQ-007 SHALL have output ports out_valid (1), out_data (DWIDTH), out_tag (TAG_W), out_ce (1, corrected single error) and out_ue (1, uncorrectable error), and input port out_ready (1).
REQ-008 SHALL have output ports scrub_req (1), scrub_data (DWIDTH), scrub_ecc (EWIDTH) and scrub_tag (TAG_W), and input port scrub_ack (1).
REQ-009 SHALL have input ports cfg_correct_en (1), cfg_scrub_en (1) and cfg_cnt_clr (1, pulse).
REQ-010 SHALL have output ports ce_cnt (CNT_W), ue_cnt (CNT_W), scrub_drop_cnt (CNT_W) and first_syn (8, {p, s[6:0]}) with first_syn_vld (1).

Function
REQ-011 SHALL use Hamming(72,64) code layout: data bit i occupies the i-th ascending non-power-of-two position in 3..71 (d0→3, d1→5, d2→6, d3→7, d4→9).
REQ-012 SHALL compute c[k] (k = 0..6) as the XOR of the data bits whose position has bit k set, and c[7] as the XOR of all data bits and c[6:0].
REQ-013 SHALL compute syndrome s[6:0] as recomputed c[6:0] XOR in_ecc[6:0], and overall parity p as the XOR of all 72 received bits.
REQ-014 SHALL classify each word as follows:
- s=0, p=0: clean.
- p=1, s in 1..71: correctable error (CE) at position s.
- p=1, s=0: CE in c[7].
- p=1, s>71: uncorrectable error (UE).
- p=0, s≠0: UE (double error).
REQ-015 SHALL, on a CE at a data position with cfg_correct_en=1, invert that data bit in out_data; a CE at a check position SHALL leave the data unchanged.
REQ-016 SHALL pass in_data unmodified when cfg_correct_en=0, while still flagging the word.
REQ-017 SHALL be a 2-stage pipeline: stage 1 registers the codeword and the s/p values, and stage 2 registers the corrected output and flags.
REQ-018 SHALL present out_valid two cycles after an in_valid&in_ready beat when there is no backpressure.
REQ-019 SHALL drive adv = ~out_valid | out_ready; both stages load only when adv=1, and in_ready = adv.
REQ-020 SHALL hold out_data, out_tag, out_ce and out_ue stable while out_valid=1 and out_ready=0.
REQ-021 SHALL increment ce_cnt and ue_cnt once per accepted output beat (out_valid&out_ready) carrying CE or UE respectively.
REQ-022 SHALL saturate ce_cnt and ue_cnt at all-ones.
REQ-023 SHALL let cfg_cnt_clr zero all counters and first_syn_vld, with clear taking precedence over a same-cycle increment.
REQ-024 SHALL, on the first CE/UE output beat while first_syn_vld=0, capture {p, s} into first_syn and set first_syn_vld.
REQ-025 SHALL implement a scrub FSM with states S_IDLE and S_REQ.
REQ-026 SHALL, in S_IDLE, on a CE output beat with cfg_scrub_en=1 and cfg_correct_en=1, load scrub_data (corrected data), scrub_ecc (freshly encoded from the corrected data) and scrub_tag, then go to S_REQ.
REQ-027 SHALL assert scrub_req exactly in S_REQ, and SHALL return to S_IDLE on scrub_ack.
REQ-028 SHALL, on a CE beat eligible for scrub while in S_REQ with no scrub_ack that cycle, drop the scrub and increment scrub_drop_cnt (saturating); a CE beat coinciding with scrub_ack SHALL reload and stay in S_REQ.
REQ-029 SHALL never issue a scrub for a UE beat.

Reset
REQ-030 SHALL, while rst_n=0 at a clk edge, clear all of the following: valid bits, out_ce, out_ue, counters, first_syn, first_syn_vld and scrub_req; the FSM SHALL go to S_IDLE.
REQ-031 SHALL hold in_ready=0 during reset.
REQ-032 SHALL discard any in-flight words and any pending scrub on reset, with no output produced for them.
REQ-033 SHALL leave out_data, out_tag and the scrub data/ecc/tag registers unreset.

Configuration
REQ-034 SHALL build the scrub FSM, the scrub ports' logic and scrub_drop_cnt only when the macro ECC_DEC_SCRUB_EN is defined.
REQ-035 SHALL, without ECC_DEC_SCRUB_EN, tie scrub_req, scrub_data, scrub_ecc, scrub_tag and scrub_drop_cnt to 0 and ignore scrub_ack; decode behaviour SHALL be unchanged.

Structure
REQ-036 SHALL place the following in package ecc_dec_pkg:
- the data-index-to-position constant table;
- the encode function;
- the scrub state enum;
- the error-class enum (CLEAN, CE, UE).
REQ-037 SHALL use one combinational sub-module, ecc_dec_syndrome, that produces s, p and the error class; the scrub encoder SHALL reuse the package encode function.

Verification
REQ-038 SHALL cover: data 64'h0, ecc 8'h00 -> out_data 64'h0, out_ce=0, out_ue=0, latency 2 cycles.
REQ-039 SHALL cover: data 64'h1, ecc 8'h00 (d0 flipped) -> s=7'h03, p=1, out_data 64'h0, out_ce=1, ce_cnt=1, first_syn=8'h83.
REQ-040 SHALL cover: data 64'h3, ecc 8'h00 -> s=7'h06, p=0, out_ue=1, out_data 64'h3, no scrub_req, ue_cnt=1.
REQ-041 SHALL cover: out_ready=0 for 5 cycles with 3 words offered -> in_ready=0 after the pipeline fills, out_data held, and all words delivered in order after release.
REQ-042 SHALL cover: two CE words back-to-back with scrub_ack held low -> one scrub_req with the first tag, scrub_drop_cnt=1; then ack -> S_IDLE.
REQ-043 SHALL cover: CNT_W=4 with 17 CE words -> ce_cnt=15; cfg_cnt_clr coinciding with a CE beat -> ce_cnt=0.
